// File: rtl/alu_op_fifo_if.sv
// Handshake and operand bus between an operation producer, the alu_op_fifo and the ALU stage.
// The slave modport is the FIFO's view; the master modport is the producer/consumer side.
interface alu_op_fifo_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_control;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_control;
    logic [31:0] out_a;
    logic [31:0] out_b;

    modport slave (
        input  in_valid, in_control, in_a, in_b, out_ready,
        output in_ready, out_valid, out_control, out_a, out_b
    );

    modport master (
        output in_valid, in_control, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_control, out_a, out_b
    );
endinterface

// File: rtl/alu_op_fifo.sv
// DEPTH-entry FIFO of ALU operations with illegal-opcode rejection.
// Optional macro ALU_OP_FIFO_SHAMT_MASK_EN masks operand b to 5 bits on shift opcodes.
module alu_op_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_op_fifo_if.slave           bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_illegal
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  control;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_errIllegal;

    logic          w_full;
    logic          w_empty;
    logic          w_offer;
    logic          w_push;
    logic          w_pop;
    logic          w_illegal;
    logic [31:0]   w_storeB;
    entry_t        w_head;

    // Acceptance depends only on registered occupancy, so a pop never frees a slot for the same cycle.
    assign w_full    = (r_count == (AW + 1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_offer   = bus.in_valid && !w_full;
    assign w_push    = w_offer && !bus.in_control[3];
    assign w_illegal = w_offer && bus.in_control[3];
    assign w_pop     = !w_empty && bus.out_ready;

    always_comb begin
        w_storeB = bus.in_b;
`ifdef ALU_OP_FIFO_SHAMT_MASK_EN
        if (bus.in_control == 4'd4 || bus.in_control == 4'd5 || bus.in_control == 4'd7) begin
            w_storeB = {27'b0, bus.in_b[4:0]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= '{control: bus.in_control, a: bus.in_a, b: w_storeB};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_errIllegal <= 1'b0;
        end else begin
            r_errIllegal <= w_illegal;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    // Head outputs read as zero whenever the FIFO holds nothing.
    assign w_head          = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.in_ready    = !w_full;
    assign bus.out_valid   = !w_empty;
    assign bus.out_control = w_head.control;
    assign bus.out_a       = w_head.a;
    assign bus.out_b       = w_head.b;
    assign count           = r_count;
    assign err_illegal     = r_errIllegal;

endmodule

// File: tb/tb_alu_op_fifo.sv
// Directed bench for alu_op_fifo: stimulus pushes expected entries into a queue,
// and a negedge monitor compares every head that is consumed.
module tb_alu_op_fifo;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    logic       err_illegal;

    op_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    alu_op_fifo_if bus ();

    alu_op_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count      (count),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic rdy, input logic accept,
                                 input logic [31:0] expB);
        bus.in_valid   = v;
        bus.in_control = c;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.out_ready  = rdy;
        if (accept) expQ.push_back('{c: c, a: a, b: expB});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        bus.in_valid  = 1'b0;
        bus.out_ready = rdy;
        repeat (n) step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (bus.out_valid !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        checkOutput({name, " drain out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({name, " drain count"}, 32'(count), 32'd0);
        checkOutput({name, " scoreboard empty"}, expQ.size(), 32'd0);
    endtask

    // A head is consumed at the next rising edge whenever valid and ready are both high now.
    always @(negedge clk) begin : monitor
        op_t e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected pop: got control %0h a %0h b %0h expected none",
                         bus.out_control, bus.out_a, bus.out_b);
            end else begin
                e = expQ.pop_front();
                checkOutput("pop control", 32'(bus.out_control), 32'(e.c));
                checkOutput("pop a", bus.out_a, e.a);
                checkOutput("pop b", bus.out_b, e.b);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] maskedB;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_control = 4'd0;
        bus.in_a       = 32'd0;
        bus.in_b       = 32'd0;
        bus.out_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;

        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_control", 32'(bus.out_control), 32'd0);
        checkOutput("reset out_a", bus.out_a, 32'd0);
        checkOutput("reset out_b", bus.out_b, 32'd0);
        checkOutput("reset err_illegal", 32'(err_illegal), 32'd0);

        $display("[TB] single push latency");
        applyStimulus(1'b1, 4'd2, 32'h5, 32'h3, 1'b0, 1'b1, 32'h3);
        checkOutput("first out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("first out_control", 32'(bus.out_control), 32'd2);
        checkOutput("first out_a", bus.out_a, 32'd5);
        checkOutput("first out_b", bus.out_b, 32'd3);
        checkOutput("first count", 32'(count), 32'd1);
        drain("first");

        $display("[TB] fill past capacity then drain");
        applyStimulus(1'b1, 4'd0, 32'hA0A0_0001, 32'h1111_1111, 1'b0, 1'b1, 32'h1111_1111);
        applyStimulus(1'b1, 4'd1, 32'hA0A0_0002, 32'h2222_2222, 1'b0, 1'b1, 32'h2222_2222);
        applyStimulus(1'b1, 4'd3, 32'hA0A0_0003, 32'h3333_3333, 1'b0, 1'b1, 32'h3333_3333);
        checkOutput("three count", 32'(count), 32'd3);
        checkOutput("three in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 4'd6, 32'hA0A0_0004, 32'h4444_4444, 1'b0, 1'b1, 32'h4444_4444);
        checkOutput("full in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("full count", 32'(count), 32'd4);
        applyStimulus(1'b1, 4'd2, 32'hA0A0_0005, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        checkOutput("overflow count", 32'(count), 32'd4);
        checkOutput("overflow head a", bus.out_a, 32'hA0A0_0001);
        drain("overflow");

        $display("[TB] full with simultaneous offer and pop");
        applyStimulus(1'b1, 4'd2, 32'hB0B0_0001, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0010);
        applyStimulus(1'b1, 4'd6, 32'hB0B0_0002, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0020);
        applyStimulus(1'b1, 4'd1, 32'hB0B0_0003, 32'h0000_0030, 1'b0, 1'b1, 32'h0000_0030);
        applyStimulus(1'b1, 4'd0, 32'hB0B0_0004, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040);
        applyStimulus(1'b1, 4'd9, 32'hDEAD_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("illegal while full err", 32'(err_illegal), 32'd0);
        checkOutput("illegal while full count", 32'(count), 32'd4);
        applyStimulus(1'b1, 4'd3, 32'hB0B0_0005, 32'h0000_0050, 1'b1, 1'b0, 32'h0);
        checkOutput("full pop count", 32'(count), 32'd3);
        applyStimulus(1'b1, 4'd3, 32'hB0B0_0005, 32'h0000_0050, 1'b0, 1'b1, 32'h0000_0050);
        checkOutput("refill count", 32'(count), 32'd4);
        checkOutput("refill head a", bus.out_a, 32'hB0B0_0002);
        drain("fullpop");

        $display("[TB] illegal opcodes");
        applyStimulus(1'b1, 4'd9, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0);
        checkOutput("illegal err pulse", 32'(err_illegal), 32'd1);
        checkOutput("illegal count", 32'(count), 32'd0);
        checkOutput("illegal out_valid", 32'(bus.out_valid), 32'd0);
        idle(1, 1'b0);
        checkOutput("illegal err cleared", 32'(err_illegal), 32'd0);
        applyStimulus(1'b1, 4'd1, 32'hC0C0_0001, 32'hC0C0_0002, 1'b0, 1'b1, 32'hC0C0_0002);
        applyStimulus(1'b1, 4'd15, 32'h3, 32'h4, 1'b0, 1'b0, 32'h0);
        checkOutput("illegal15 err pulse", 32'(err_illegal), 32'd1);
        checkOutput("illegal15 count", 32'(count), 32'd1);
        drain("illegal");
        checkOutput("illegal15 err cleared", 32'(err_illegal), 32'd0);

        $display("[TB] streaming push and pop together");
        applyStimulus(1'b1, 4'd2, 32'hD000_0001, 32'h1, 1'b0, 1'b1, 32'h1);
        applyStimulus(1'b1, 4'd6, 32'hD000_0002, 32'h2, 1'b1, 1'b1, 32'h2);
        checkOutput("stream count a", 32'(count), 32'd1);
        applyStimulus(1'b1, 4'd3, 32'hD000_0003, 32'h3, 1'b1, 1'b1, 32'h3);
        applyStimulus(1'b1, 4'd0, 32'hD000_0004, 32'h4, 1'b1, 1'b1, 32'h4);
        checkOutput("stream count b", 32'(count), 32'd1);
        checkOutput("stream head a", bus.out_a, 32'hD000_0004);
        drain("stream");

        $display("[TB] shift amount operand");
`ifdef ALU_OP_FIFO_SHAMT_MASK_EN
        maskedB = 32'h0000_0005;
`else
        maskedB = 32'h0000_0025;
`endif
        applyStimulus(1'b1, 4'd4, 32'h1, 32'h0000_0025, 1'b0, 1'b1, maskedB);
        checkOutput("sll out_b", bus.out_b, maskedB);
`ifdef ALU_OP_FIFO_SHAMT_MASK_EN
        maskedB = 32'h0000_0003;
`else
        maskedB = 32'hFFFF_FFE3;
`endif
        applyStimulus(1'b1, 4'd7, 32'h8000_0000, 32'hFFFF_FFE3, 1'b0, 1'b1, maskedB);
        applyStimulus(1'b1, 4'd3, 32'h1, 32'h0000_0025, 1'b0, 1'b1, 32'h0000_0025);
        drain("shamt");

        $display("[TB] reset during traffic");
        applyStimulus(1'b1, 4'd0, 32'hE000_0001, 32'h1, 1'b0, 1'b1, 32'h1);
        applyStimulus(1'b1, 4'd1, 32'hE000_0002, 32'h2, 1'b0, 1'b1, 32'h2);
        applyStimulus(1'b1, 4'd2, 32'hE000_0003, 32'h3, 1'b0, 1'b1, 32'h3);
        checkOutput("prereset count", 32'(count), 32'd3);
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_control = 4'd2;
        bus.in_a       = 32'hE000_0004;
        bus.in_b       = 32'h4;
        bus.out_ready  = 1'b1;
        step();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        expQ.delete();
        checkOutput("midreset count", 32'(count), 32'd0);
        checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midreset out_control", 32'(bus.out_control), 32'd0);
        checkOutput("midreset out_a", bus.out_a, 32'd0);
        checkOutput("midreset out_b", bus.out_b, 32'd0);

        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_control = 4'd12;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("reset over illegal err", 32'(err_illegal), 32'd0);
        checkOutput("reset over illegal count", 32'(count), 32'd0);

        applyStimulus(1'b1, 4'd6, 32'hF000_0001, 32'hF000_0002, 1'b0, 1'b1, 32'hF000_0002);
        checkOutput("postreset head a", bus.out_a, 32'hF000_0001);
        drain("postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
